// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU: accept, execute one cycle, hold response.
// Optional build macro ALU_ARB_OVF_TRAP_EN: an ADD/SUB overflow becomes a trap with the result zeroed.
module alu_arbiter #(
  parameter int unsigned START_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_imm_sel,
  input  logic [4:0]  req0_sa,
  input  logic [3:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_imm_sel,
  input  logic [4:0]  req1_sa,
  input  logic [3:0]  req1_ctrl,
  output logic        alu_src,
  output logic [31:0] alu_a,
  output logic [31:0] alu_rd2,
  output logic [31:0] alu_imm,
  output logic [4:0]  alu_sa,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        rsp_trap,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a requester keeps valid and payload stable until then, ready never waits on anything but state.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic PRIO_RST = (START_PRIO != 0);

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        grant0, grant1, accept;

  logic        id_q;
  logic [31:0] a_q, b_q;
  logic        imm_sel_q;
  logic [4:0]  sa_q;
  logic [3:0]  ctrl_q;

  logic        rsp_id_q, rsp_zero_q, rsp_ovf_q, rsp_trap_q;
  logic [31:0] rsp_result_q;
  logic        trap_d;
  logic [31:0] result_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = req0_valid && (!req1_valid || !prio_q);
      grant1 = req1_valid && (!req0_valid || prio_q);
    end
    accept = grant0 | grant1;
  end

  // Gated by rst_n so nothing is offered while reset is held.
  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          prio_d  = grant0;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= PRIO_RST;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      imm_sel_q <= 1'b0;
      sa_q      <= '0;
      ctrl_q    <= '0;
    end else if (accept) begin
      id_q      <= grant1;
      a_q       <= grant1 ? req1_a       : req0_a;
      b_q       <= grant1 ? req1_b       : req0_b;
      imm_sel_q <= grant1 ? req1_imm_sel : req0_imm_sel;
      sa_q      <= grant1 ? req1_sa      : req0_sa;
      ctrl_q    <= grant1 ? req1_ctrl    : req0_ctrl;
    end
  end

  // Operand B is steered to exactly one ALU port; everything idles at zero outside EXEC.
  always_comb begin
    alu_src  = 1'b0;
    alu_a    = '0;
    alu_rd2  = '0;
    alu_imm  = '0;
    alu_sa   = '0;
    alu_ctrl = '0;
    if (state_q == EXEC) begin
      alu_src  = imm_sel_q;
      alu_a    = a_q;
      alu_sa   = sa_q;
      alu_ctrl = ctrl_q;
      if (imm_sel_q) alu_imm = b_q;
      else           alu_rd2 = b_q;
    end
  end

`ifdef ALU_ARB_OVF_TRAP_EN
  always_comb begin
    trap_d   = alu_ovf && ((ctrl_q == 4'b0000) || (ctrl_q == 4'b0010));
    result_d = trap_d ? 32'd0 : alu_result;
  end
`else
  always_comb begin
    trap_d   = 1'b0;
    result_d = alu_result;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_trap_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_id_q     <= id_q;
      rsp_result_q <= result_d;
      rsp_zero_q   <= alu_zero;
      rsp_ovf_q    <= alu_ovf;
      rsp_trap_q   <= trap_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_ovf     = rsp_ovf_q;
  assign rsp_trap    = rsp_trap_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table through a small ALU model, plus arbitration, stall and reset sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_imm_sel;
  logic [31:0] req0_a, req0_b;
  logic [4:0]  req0_sa;
  logic [3:0]  req0_ctrl;
  logic        req1_valid, req1_ready, req1_imm_sel;
  logic [31:0] req1_a, req1_b;
  logic [4:0]  req1_sa;
  logic [3:0]  req1_ctrl;
  logic        alu_src;
  logic [31:0] alu_a, alu_rd2, alu_imm, alu_result;
  logic [4:0]  alu_sa;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_ovf;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_ovf, rsp_trap;
  logic [31:0] rsp_result;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.START_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_imm_sel(req0_imm_sel), .req0_sa(req0_sa), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_imm_sel(req1_imm_sel), .req1_sa(req1_sa), .req1_ctrl(req1_ctrl),
    .alu_src(alu_src), .alu_a(alu_a), .alu_rd2(alu_rd2), .alu_imm(alu_imm),
    .alu_sa(alu_sa), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_trap(rsp_trap), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Shared ALU: 0000 ADD, 0010 SUB, 0011 SLL b by sa, 1001 XOR, 1111 pass A with ovf forced.
  logic [31:0] alu_bop;
  always_comb begin
    alu_bop    = alu_src ? alu_imm : alu_rd2;
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (alu_ctrl)
      4'b0000: begin
        alu_result = alu_a + alu_bop;
        alu_ovf    = (alu_a[31] == alu_bop[31]) && (alu_result[31] != alu_a[31]);
      end
      4'b0010: begin
        alu_result = alu_a - alu_bop;
        alu_ovf    = (alu_a[31] != alu_bop[31]) && (alu_result[31] != alu_a[31]);
      end
      4'b0011: alu_result = alu_bop << alu_sa;
      4'b1001: alu_result = alu_a ^ alu_bop;
      4'b1111: begin
        alu_result = alu_a;
        alu_ovf    = 1'b1;
      end
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic        imm;
    logic [4:0]  sa;
    logic [3:0]  ctrl;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ovf;
    logic        exp_trap;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [31:0] a, input logic [31:0] b,
                       input logic imm, input logic [4:0] sa, input logic [3:0] ctrl);
    if (!p) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_imm_sel = imm; req0_sa = sa; req0_ctrl = ctrl;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_imm_sel = imm; req1_sa = sa; req1_ctrl = ctrl;
    end
  endtask

  task automatic drop(input logic p);
    if (!p) req0_valid = 1'b0;
    else    req1_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where the port sees ready, or times out.
  task automatic wait_ready(input logic p, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((p ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_vector(input vec_t v);
    logic ok;
    @(negedge clk);
    drive(v.port, v.a, v.b, v.imm, v.sa, v.ctrl);
    wait_ready(v.port, ok);
    check("vec_accept", {31'd0, ok}, 32'd1);
    if (!ok) begin
      drop(v.port);
      return;
    end
    @(posedge clk);
    #1 drop(v.port);
    @(negedge clk);
    check("vec_exec_state", {30'd0, dbg_state}, 32'd1);
    check("vec_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("vec_alu_src", {31'd0, alu_src}, {31'd0, v.imm});
    check("vec_alu_a", alu_a, v.a);
    check("vec_alu_rd2", alu_rd2, v.imm ? 32'd0 : v.b);
    check("vec_alu_imm", alu_imm, v.imm ? v.b : 32'd0);
    check("vec_alu_sa", {27'd0, alu_sa}, {27'd0, v.sa});
    check("vec_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, v.ctrl});
    @(negedge clk);
    check("vec_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("vec_rsp_id", {31'd0, rsp_id}, {31'd0, v.port});
    check("vec_rsp_result", rsp_result, v.exp_res);
    check("vec_rsp_zero", {31'd0, rsp_zero}, {31'd0, v.exp_zero});
    check("vec_rsp_ovf", {31'd0, rsp_ovf}, {31'd0, v.exp_ovf});
    check("vec_rsp_trap", {31'd0, rsp_trap}, {31'd0, v.exp_trap});
    @(negedge clk);
    check("vec_back_idle", {30'd0, dbg_state}, 32'd0);
    check("vec_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd10, 32'd20, 1'b0, 5'd0, 4'b0000, 32'd30, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'd9, 32'd4, 1'b0, 5'd0, 4'b0010, 32'd5, 1'b0, 1'b0, 1'b0};
`ifdef ALU_ARB_OVF_TRAP_EN
    vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'd1, 1'b0, 5'd0, 4'b0000, 32'd0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h80000000, 32'd1, 1'b0, 5'd0, 4'b0010, 32'd0, 1'b0, 1'b1, 1'b1};
`else
    vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'd1, 1'b0, 5'd0, 4'b0000, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'h80000000, 32'd1, 1'b0, 5'd0, 4'b0010, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
`endif
    vecs[3] = '{1'b1, 32'd7, 32'd7, 1'b0, 5'd0, 4'b1001, 32'd0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'd10, 32'd5, 1'b1, 5'd0, 4'b0000, 32'd15, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'd0, 32'd1, 1'b0, 5'd4, 4'b0011, 32'd16, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h1234, 32'd0, 1'b0, 5'd0, 4'b1111, 32'h1234, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 32'd100, 32'd1, 1'b1, 5'd0, 4'b0010, 32'd99, 1'b0, 1'b0, 1'b0};

    // Reset with a request already pending.
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_imm_sel = 1'b0; req0_sa = '0; req0_ctrl = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_imm_sel = 1'b0; req1_sa = '0; req1_ctrl = '0;
    drive(1'b0, 32'd1, 32'd1, 1'b0, 5'd0, 4'b0000);
    repeat (2) @(negedge clk);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);

    // Both valid out of reset: port0 first, then pointer alternates.
    drive(1'b1, 32'd9, 32'd4, 1'b0, 5'd0, 4'b0010);
    rst_n = 1'b1;
    #1;
    check("arb_first_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("arb_first_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    #1 drop(1'b0);
    @(negedge clk);
    check("arb_exec_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    check("arb_rsp0_valid", {31'd0, rsp_valid}, 32'd1);
    check("arb_rsp0_id", {31'd0, rsp_id}, 32'd0);
    check("arb_rsp0_result", rsp_result, 32'd2);
    @(negedge clk);
    check("arb_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    #1 drop(1'b1);
    repeat (2) @(negedge clk);
    check("arb_rsp1_id", {31'd0, rsp_id}, 32'd1);
    check("arb_rsp1_result", rsp_result, 32'd5);
    @(negedge clk);
    drive(1'b0, 32'd1, 32'd1, 1'b0, 5'd0, 4'b0000);
    drive(1'b1, 32'd9, 32'd4, 1'b0, 5'd0, 4'b0010);
    #1;
    check("arb_rr_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("arb_rr_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    #1 drop(1'b0);
    repeat (3) @(negedge clk);
    drive(1'b0, 32'd1, 32'd1, 1'b0, 5'd0, 4'b0000);
    #1;
    check("arb_rr2_req1_ready", {31'd0, req1_ready}, 32'd1);
    check("arb_rr2_req0_ready", {31'd0, req0_ready}, 32'd0);
    @(posedge clk);
    #1 begin drop(1'b0); drop(1'b1); end
    repeat (2) @(negedge clk);
    check("arb_rr2_rsp_id", {31'd0, rsp_id}, 32'd1);
    @(negedge clk);

    // Response stall with port1 waiting.
    rsp_ready = 1'b0;
    drive(1'b0, 32'd3, 32'd4, 1'b0, 5'd0, 4'b0000);
    #1 check("stall_req0_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    #1 begin
      drop(1'b0);
      drive(1'b1, 32'd9, 32'd4, 1'b0, 5'd0, 4'b0010);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_result", rsp_result, 32'd7);
      check("stall_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("stall_req1_ready", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("stall_release_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    check("stall_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("stall_idle_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    #1 drop(1'b1);
    repeat (2) @(negedge clk);
    check("stall_rsp1_id", {31'd0, rsp_id}, 32'd1);
    check("stall_rsp1_result", rsp_result, 32'd5);
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vector(vecs[i]);

    // Reset pulse while an operation is in EXEC.
    @(negedge clk);
    drive(1'b0, 32'd10, 32'd20, 1'b0, 5'd0, 4'b0000);
    @(posedge clk);
    #1 drop(1'b0);
    @(negedge clk);
    check("rstx_exec_alu_a", alu_a, 32'd10);
    #1 rst_n = 1'b0;
    #1;
    check("rstx_alu_a", alu_a, 32'd0);
    check("rstx_alu_rd2", alu_rd2, 32'd0);
    check("rstx_state", {30'd0, dbg_state}, 32'd0);
    check("rstx_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstx_rsp_result", rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rstx_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter START_PRIO, default 0, SHALL select the requester port holding priority after reset (0 or 1).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 Ports reqN_valid  input  1 (N=0,1) SHALL flag a pending ALU operation from requester N.
REQ-005 Ports reqN_ready  output  1 SHALL flag acceptance of requester N's operation this cycle.
REQ-006 Ports reqN_a, reqN_b  input  32 SHALL carry operand A and operand B or immediate.
REQ-007 Ports reqN_imm_sel  input  1, reqN_sa  input  5, reqN_ctrl  input  4 SHALL carry ALUSrc, shift amount and aluCtrl code.
REQ-008 Ports alu_src  output  1, alu_a, alu_rd2, alu_imm  output  32, alu_sa  output  5, alu_ctrl  output  4 SHALL drive the shared ALU inputs.
REQ-009 Ports alu_result  input  32, alu_zero  input  1, alu_ovf  input  1 SHALL receive the ALU outputs.
REQ-010 Ports rsp_valid  output  1, rsp_ready  input  1 SHALL form the response handshake.
REQ-011 Ports rsp_id  output  1, rsp_result  output  32, rsp_zero  output  1, rsp_ovf  output  1, rsp_trap  output  1 SHALL carry the response payload.

Function
REQ-012 FSM states SHALL be IDLE, EXEC, RESP; transitions IDLE->EXEC on acceptance, EXEC->RESP unconditionally, RESP->IDLE when rsp_ready=1.
REQ-013 In IDLE, grant SHALL go to the sole valid port, or to the priority port if both valid; reqN_ready=1 only for the granted port in IDLE, 0 in all other states.
REQ-014 On acceptance the priority pointer SHALL move to the non-granted port (round-robin); no acceptance leaves it unchanged.
REQ-015 Accepted payload SHALL be registered; requesters hold payload stable while valid=1 and ready=0.
REQ-016 In EXEC, ALU outputs SHALL present registered operands: alu_src=imm_sel; b to alu_imm if imm_sel=1 else alu_rd2; unused operand port 0.
REQ-017 Outside EXEC, all alu_* outputs SHALL be 0.
REQ-018 At end of EXEC, alu_result/zero/ovf and grant id SHALL be captured into rsp_* registers; rsp_valid=1 on the cycle after EXEC (accept at cycle N, rsp_valid at N+2).
REQ-019 In RESP, rsp_valid and payload SHALL remain stable until rsp_ready=1; no new request accepted meanwhile.
REQ-020 rsp_valid SHALL be 0 in IDLE and EXEC; minimum spacing between accepts is 3 cycles.

Reset
REQ-021 rst_n=0 SHALL force IDLE, priority pointer=START_PRIO, all outputs 0, regardless of state (including mid EXEC/RESP; in-flight operation discarded).
REQ-022 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-023 Macro ALU_ARB_OVF_TRAP_EN defined: when captured ovf=1 and ctrl is 0000 (ADD) or 0010 (SUB), rsp_trap=1 and rsp_result=0; else rsp_trap=0.
REQ-024 Macro undefined: rsp_trap SHALL be constant 0 and rsp_result always equals captured alu_result.

Verification
REQ-025 Port0 only, ctrl=0000, a=10, b=20, imm_sel=0 -> rsp_valid at accept+2, rsp_id=0, rsp_result=30, rsp_zero=0.
REQ-026 After reset START_PRIO=0, both valid same cycle (port0 ADD 1+1, port1 SUB 9-4) -> port0 response (2) first, then port1 response (5); pointer alternates.
REQ-027 rsp_ready low 5 cycles with req1_valid=1 -> rsp_* stable, req1_ready=0 throughout, accepted only in IDLE after handshake.
REQ-028 ctrl=0000, a=0x7FFFFFFF, b=1 -> macro defined: rsp_trap=1, rsp_result=0; undefined: rsp_result=0x80000000, rsp_ovf=1, rsp_trap=0.
REQ-029 ctrl=1001, a=7, b=7 -> rsp_zero=1, rsp_result=0; ctrl=0000, imm_sel=1, a=10, b=5 -> alu_src=1 in EXEC, rsp_result=15.
REQ-030 rst_n pulsed low during EXEC -> alu_* and rsp_* 0 asynchronously, state IDLE, no response emitted for that operation.
